// File: rtl/prog_clk_divider_if.sv
// prog_clk_divider_if
//   Groups the control and status signals of the programmable clock divider.
//   Parameters must match the prog_clk_divider instance that uses it.
//   Signals:
//     en       [N_CH]        per-channel run enable
//     restart                synchronous pulse that reloads and realigns all channels
//     accel    [N_CH*WIDTH]  per-channel accelerator, channel i at [i*WIDTH +: WIDTH]
//     clk_out  [N_CH]        divided 50%-duty square wave per channel
//     tick     [N_CH]        one-cycle strobe on each clk_out toggle
//     period_o [N_CH*WIDTH]  latched effective half-period, same packing as accel
//   Modports: master drives the controls, slave is the divider.
interface prog_clk_divider_if #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned WIDTH = 25
);
  logic [N_CH-1:0]       en;
  logic                  restart;
  logic [N_CH*WIDTH-1:0] accel;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;
  logic [N_CH*WIDTH-1:0] period_o;

  modport master (
    output en, restart, accel,
    input  clk_out, tick, period_o
  );

  modport slave (
    input  en, restart, accel,
    output clk_out, tick, period_o
  );
endinterface

// File: rtl/prog_clk_divider.sv
// prog_clk_divider
//   Multi-channel programmable clock divider / tick generator. Each channel
//   produces a 50%-duty divided clock and a one-cycle tick on every toggle.
//   The half-period is BASE_PERIOD - accel, clamped to MIN_PERIOD, and is only
//   latched at terminal count (or while idle / on restart), so the divided
//   output never glitches when accel changes mid-count.
//   Ports:
//     clk    system clock, all logic on rising edge
//     rst_n  synchronous active-low reset
//     bus    prog_clk_divider_if.slave (en, restart, accel, clk_out, tick, period_o)
module prog_clk_divider #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned WIDTH       = 25,
  parameter int unsigned BASE_PERIOD = 25000000,
  parameter int unsigned MIN_PERIOD  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prog_clk_divider_if.slave     bus
);

  localparam logic [WIDTH-1:0] BASE_W   = WIDTH'(BASE_PERIOD);
  localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_PERIOD);
  // Clamp threshold held one bit wider so accel values above BASE cannot wrap.
  localparam logic [WIDTH:0]   THRESH_X = (WIDTH+1)'(BASE_PERIOD - MIN_PERIOD);

  logic [WIDTH-1:0]      cnt_q [N_CH];
  logic [WIDTH-1:0]      cnt_d [N_CH];
  logic [WIDTH-1:0]      p_eff [N_CH];
  logic [N_CH*WIDTH-1:0] per_q;
  logic [N_CH*WIDTH-1:0] per_d;
  logic [N_CH-1:0]       clk_out_q;
  logic [N_CH-1:0]       clk_out_d;
  logic [N_CH-1:0]       tick_q;
  logic [N_CH-1:0]       tick_d;

  // Effective half-period from the live accelerator value.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      if ({1'b0, bus.accel[i*WIDTH +: WIDTH]} >= THRESH_X) begin
        p_eff[i] = MIN_W;
      end else begin
        p_eff[i] = BASE_W - bus.accel[i*WIDTH +: WIDTH];
      end
    end
  end

  // Per-channel next state: restart > disabled > count.
  always_comb begin
    per_d     = per_q;
    clk_out_d = clk_out_q;
    tick_d    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.restart) begin
        cnt_d[i]               = '0;
        clk_out_d[i]           = 1'b0;
        per_d[i*WIDTH +: WIDTH] = p_eff[i];
      end else if (!bus.en[i]) begin
        cnt_d[i]               = '0;
        per_d[i*WIDTH +: WIDTH] = p_eff[i];
      end else if (cnt_q[i] == per_q[i*WIDTH +: WIDTH] - WIDTH'(1)) begin
        cnt_d[i]               = '0;
        clk_out_d[i]           = ~clk_out_q[i];
        tick_d[i]              = 1'b1;
        per_d[i*WIDTH +: WIDTH] = p_eff[i];
      end else begin
        cnt_d[i] = cnt_q[i] + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      per_q     <= {N_CH{BASE_W}};
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      per_q     <= per_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.clk_out  = clk_out_q;
  assign bus.tick     = tick_q;
  assign bus.period_o = per_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider
//   Bench for prog_clk_divider (N_CH=2, WIDTH=8, BASE_PERIOD=10, MIN_PERIOD=2).
//   A countdown reference model pushes the expected outputs for every edge
//   into a scoreboard queue; a monitor pops and compares after each edge.
//   Directed checks of tick spacing and period_o use fixed expected constants.
module tb_prog_clk_divider;

  localparam int N_CH  = 2;
  localparam int WIDTH = 8;
  localparam int BASE  = 10;
  localparam int MINP  = 2;

  typedef struct packed {
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [15:0] per;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] tb_en;
  logic       tb_restart;
  int         tb_accel [2];

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb_q [$];

  // Reference model state (countdown form).
  int   m_per [2];
  int   m_rem [2];
  logic [1:0] m_clk;
  logic [1:0] m_tick;

  prog_clk_divider_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus_if ();

  prog_clk_divider #(
    .N_CH(N_CH), .WIDTH(WIDTH), .BASE_PERIOD(BASE), .MIN_PERIOD(MINP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  assign bus_if.en      = tb_en;
  assign bus_if.restart = tb_restart;
  assign bus_if.accel   = {8'(tb_accel[1]), 8'(tb_accel[0])};

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int peff(input int a);
    if (a >= BASE - MINP) return MINP;
    return BASE - a;
  endfunction

  task automatic model_step();
    for (int ch = 0; ch < 2; ch++) begin
      if (!rst_n) begin
        m_per[ch] = BASE; m_rem[ch] = BASE; m_clk[ch] = 1'b0; m_tick[ch] = 1'b0;
      end else if (tb_restart) begin
        m_per[ch] = peff(tb_accel[ch]); m_rem[ch] = m_per[ch];
        m_clk[ch] = 1'b0; m_tick[ch] = 1'b0;
      end else if (!tb_en[ch]) begin
        m_per[ch] = peff(tb_accel[ch]); m_rem[ch] = m_per[ch]; m_tick[ch] = 1'b0;
      end else begin
        m_rem[ch]--;
        m_tick[ch] = 1'b0;
        if (m_rem[ch] == 0) begin
          m_clk[ch]  = ~m_clk[ch];
          m_tick[ch] = 1'b1;
          m_per[ch]  = peff(tb_accel[ch]);
          m_rem[ch]  = m_per[ch];
        end
      end
    end
  endtask

  // Inputs are set by the caller; predict the coming edge and wait past it.
  task automatic drive_cycle();
    exp_t e;
    model_step();
    e.clk_out = m_clk;
    e.tick    = m_tick;
    e.per     = {8'(m_per[1]), 8'(m_per[0])};
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) drive_cycle();
  endtask

  // Edges until tick[ch] is seen; budget+1 on timeout.
  task automatic wait_tick(input int ch, input int budget, output int n);
    bit done = 1'b0;
    n = budget + 1;
    for (int k = 1; k <= budget; k++) begin
      if (!done) begin
        drive_cycle();
        if (bus_if.tick[ch]) begin
          n = k;
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_val("sb_clk_out", 32'(bus_if.clk_out), 32'(e.clk_out));
        check_val("sb_tick", 32'(bus_if.tick), 32'(e.tick));
        check_val("sb_period", 32'(bus_if.period_o), 32'(e.per));
      end
    end
  end

  initial begin : stim
    int n;
    m_per = '{0, 0}; m_rem = '{0, 0}; m_clk = '0; m_tick = '0;
    rst_n = 1'b0; tb_en = 2'b11; tb_restart = 1'b1; tb_accel = '{0, 0};

    // Reset dominates en and restart.
    run(3);
    check_val("rst_clk_out", 32'(bus_if.clk_out), 32'd0);
    check_val("rst_tick", 32'(bus_if.tick), 32'd0);
    check_val("rst_period", 32'(bus_if.period_o), 32'h0A0A);

    rst_n = 1'b1; tb_restart = 1'b0;
    wait_tick(0, 30, n); check_val("first_tick0", n, 10);
    check_val("clk0_after10", 32'(bus_if.clk_out[0]), 1);
    wait_tick(0, 30, n); check_val("second_tick0", n, 10);
    check_val("clk0_after20", 32'(bus_if.clk_out[0]), 0);
    wait_tick(0, 30, n); check_val("third_tick0", n, 10);
    check_val("clk0_after30", 32'(bus_if.clk_out[0]), 1);

    // Acceleration and clamp.
    tb_accel[0] = 4;
    wait_tick(0, 30, n);
    wait_tick(0, 30, n); check_val("accel4_tick", n, 6);
    check_val("accel4_period", 32'(bus_if.period_o[7:0]), 6);
    wait_tick(0, 30, n); check_val("accel4_tick2", n, 6);
    tb_accel[0] = 7;
    wait_tick(0, 30, n);
    wait_tick(0, 30, n); check_val("accel7_tick", n, 3);
    check_val("accel7_period", 32'(bus_if.period_o[7:0]), 3);
    foreach (tb_accel[k]) begin end
    tb_accel[0] = 8;
    wait_tick(0, 30, n);
    wait_tick(0, 30, n); check_val("accel8_tick", n, 2);
    tb_accel[0] = 9;
    run(6);
    check_val("accel9_period", 32'(bus_if.period_o[7:0]), 2);
    tb_accel[0] = 200;
    run(6);
    check_val("accel200_period", 32'(bus_if.period_o[7:0]), 2);
    wait_tick(0, 30, n); check_val("accel200_tick", n, 2);

    // Mid-count accel change does not disturb the half-period in progress.
    tb_accel[0] = 0; tb_restart = 1'b1; run(1); tb_restart = 1'b0;
    run(5);
    tb_accel[0] = 8;
    wait_tick(0, 30, n); check_val("glitch_finish", n, 5);
    wait_tick(0, 30, n); check_val("glitch_after", n, 2);

    // Enable gating and channel independence.
    tb_accel[0] = 0; tb_accel[1] = 3; tb_en = 2'b01;
    run(12);
    check_val("idle_tick1", 32'(bus_if.tick[1]), 0);
    check_val("idle_period1", 32'(bus_if.period_o[15:8]), 7);
    tb_en = 2'b11;
    wait_tick(1, 30, n); check_val("en1_first_tick", n, 7);
    run(20);

    // Restart alignment.
    tb_accel[0] = 0; tb_accel[1] = 5;
    run(13);
    tb_restart = 1'b1; run(1); tb_restart = 1'b0;
    check_val("restart_clk_out", 32'(bus_if.clk_out), 0);
    wait_tick(1, 30, n); check_val("restart_tick1", n, 5);
    wait_tick(0, 30, n); check_val("restart_tick0", n, 5);
    check_val("restart_coincide", 32'(bus_if.tick), 3);

    // Reset in the middle of a high half-period.
    tb_accel = '{0, 0};
    tb_restart = 1'b1; run(1); tb_restart = 1'b0;
    run(17);
    check_val("pre_rst_clk0", 32'(bus_if.clk_out[0]), 1);
    rst_n = 1'b0; run(1); rst_n = 1'b1;
    check_val("mid_rst_clk_out", 32'(bus_if.clk_out), 0);
    check_val("mid_rst_tick", 32'(bus_if.tick), 0);
    check_val("mid_rst_period", 32'(bus_if.period_o), 32'h0A0A);
    wait_tick(0, 30, n); check_val("mid_rst_first_tick", n, 10);

    // Randomised traffic, model-checked every edge.
    for (int r = 0; r < 40; r++) begin
      tb_accel[0] = $urandom_range(0, 14);
      tb_accel[1] = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 12);
      tb_en       = 2'($urandom_range(0, 3) != 0 ? 3 : $urandom_range(0, 3));
      tb_restart  = ($urandom_range(0, 15) == 0);
      run(1);
      tb_restart  = 1'b0;
      run($urandom_range(2, 12));
    end

    run(2);
    check_val("sb_drained", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
- Multi-channel programmable clock divider and tick generator for the game timing path: sprite movement, scroll speed, and the per-lane speed-up under the accelerator control.
- Each channel derives from the system clock:
  - a 50%-duty divided square wave, and
  - a one-cycle tick strobe.
- Each channel's half-period is base period minus its accelerator value, clamped to a floor.
- Period changes take effect only at terminal count, so the divided output never glitches.
- A global restart input phase-aligns all channels.

Parameters:
N_CH, 2, number of independent divider channels (1..8)
WIDTH, 25, width of counters, accelerator inputs and period values
BASE_PERIOD, 25000000, half-period in clk cycles when accelerator = 0 (must fit WIDTH bits)
MIN_PERIOD, 2, lower clamp on effective half-period (1 <= MIN_PERIOD <= BASE_PERIOD)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
en  input  N_CH  per-channel run enable
restart  input  1  synchronous pulse: reload and realign all channels
accel  input  N_CH*WIDTH  per-channel accelerator; channel i at bits [i*WIDTH +: WIDTH]
clk_out  output  N_CH  divided square wave per channel, registered
tick  output  N_CH  one-cycle strobe per channel, high on each clk_out toggle, registered
period_o  output  N_CH*WIDTH  currently latched effective half-period per channel, same packing as accel

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Effective period, computed each cycle per channel: p_eff = BASE_PERIOD - accel.
  - If accel >= BASE_PERIOD - MIN_PERIOD, p_eff = MIN_PERIOD; covers underflow (accel > BASE) and accel = BASE.
  - Compare at WIDTH+1 bits; no wrap-around is permitted.
- Per-channel state: cnt (WIDTH bits), per (WIDTH bits, latched p_eff), clk_out, tick.
- Reset (rst_n=0 at an edge), all channels:
  - cnt = 0, clk_out = 0, tick = 0
  - per = BASE_PERIOD, so period_o = BASE_PERIOD
  - reset overrides restart and en.
- Priority per edge, rst_n=1: restart > en low > count.
- restart=1:
  - every channel: cnt = 0, clk_out = 0, tick = 0, per = current p_eff
  - applies regardless of en.
- en[i]=0:
  - cnt = 0, tick = 0, clk_out held at its current value
  - per reloaded with p_eff each cycle, so it tracks accel while idle.
- en[i]=1, cnt != per-1: cnt = cnt + 1, tick = 0.
- en[i]=1, cnt == per-1 (terminal count):
  - cnt = 0, clk_out toggles, tick = 1
  - per = current p_eff.
- Period timing:
  - A new accel value affects timing only from the next terminal count; the half-period in progress completes at the old per.
  - Changing accel mid-count, even to below the current cnt, never truncates or extends the current half-period.
- Timing from enable or restart:
  - tick first rises after the per-th rising edge with en=1 after reset release, restart, or en rising.
  - After that, tick rises every per edges.
  - clk_out period = 2*per cycles.
- MIN_PERIOD = 1 (per = 1): tick stays high continuously and clk_out toggles every cycle (clk/2).
- Independence: channels share no state except restart and rst_n.
- Outputs: all registered; there is no combinational path from inputs to outputs.

Test Plan:
- Bench parameters for all scenarios: N_CH=2, WIDTH=8, BASE_PERIOD=10, MIN_PERIOD=2.
- Reset: rst_n=0 for 3 edges with en=11, restart=1 -> clk_out=00, tick=00, period_o=10/10. Release rst_n, accel=0 -> tick[0] high after edge 10, 20, 30; clk_out[0] reads 1,0,1 after those edges.
- Acceleration: accel0=4 -> period_o[0]=6, tick every 6 edges, clk_out period 12. Set accel0=7 -> per=3. Set accel0=8, 9, 200 -> per=2 (clamp); period_o[0] never wraps.
- Glitch-free update: accel0=0, change accel0 to 8 at cnt=5 -> current half-period still ends at 10 edges, then ticks every 2 edges.
- Enable and independence: en=01 with accel1=3 -> clk_out[1] holds, tick[1]=0, period_o[1]=7. Raise en[1] -> first tick[1] after edge 7. Channel 0 timing is unaffected throughout.
- Restart alignment: channels at accel0=0 and accel1=5, mid-count -> pulse restart for 1 cycle -> both clk_out=0, both cnt=0. tick[1] after edge 5, tick[0] after edge 10. Both ticks coincide after edge 10.
- Reset mid-operation: assert rst_n=0 one edge while clk_out=1 and cnt=7 -> next edge shows clk_out=0, tick=0, period_o=10. The counting sequence restarts exactly as in the reset scenario.
